// File: rtl/mul_seq_ctrl.sv
// Iterative RV32M multiply sequencer: radix-2 shift-add over XLEN cycles on operand
// magnitudes, sign fix-up in a final cycle, then a registered result with a done pulse.
module mul_seq_ctrl #(
    parameter int XLEN = 32,
    parameter int CW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [1:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed_s;
    logic                b_signed_s;
    logic [XLEN:0]       sum_s;
    logic [2*XLEN-1:0]   product_s;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        // -2^(XLEN-1) maps onto itself, which is the correct unsigned magnitude
        if (is_signed && v[XLEN-1]) begin
            return ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

    // Next-state, datapath and output computation for the multiply sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        op_d       = op_q;
        neg_d      = neg_q;
        done_d     = 1'b0;
        result_d   = result_q;
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU);
        b_signed_s = (op == OP_MULH);
        sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        product_s  = neg_q ? negate_wide(acc_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    // acc_lo doubles as the multiplier shift register
                    mcand_d = magnitude(op_a, a_signed_s);
                    acc_d   = {{XLEN{1'b0}}, magnitude(op_b, b_signed_s)};
                    op_d    = op;
                    neg_d   = (a_signed_s & op_a[XLEN-1]) ^ (b_signed_s & op_b[XLEN-1]);
                    cnt_d   = CW'(XLEN - 1);
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = {sum_s, acc_q[XLEN-1:1]};
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_q == OP_MUL) begin
                        result_d = product_s[XLEN-1:0];
                    end else begin
                        result_d = product_s[2*XLEN-1:XLEN];
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: exact-latency checks of each op, back-to-back
// issue, ignored start while busy, kill and asynchronous reset mid-operation.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    mul_seq_ctrl #(.XLEN(32), .CW(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Issues an op in the current cycle (cycle 0); returns in the done cycle (cycle 34).
    // A stray start at cycle 10 must be ignored; operands change while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
        logic ok;
        start = 1'b1; op = o; op_a = a; op_b = b;
        tick();
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            start = (c == 10);
            if (c == 10) begin
                op = 2'b11; op_a = 32'h0000_0009; op_b = 32'h0000_0009;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_busy_window"}, {31'd0, ok}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, result, expv);
    endtask

    initial begin
        logic ok;
        reset = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; op_a = 32'd0; op_b = 32'd0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b1;
        tick();

        run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, "mul_7x6");
        tick();
        chk("mul_7x6_done_pulse", {31'd0, done}, 32'd0);
        chk("mul_7x6_result_hold", result, 32'h0000_002A);

        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
        tick();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
        tick();
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        tick();
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        tick();
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mul_min");
        tick();
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, "mulh_neg");
        tick();

        // Back-to-back: second start lands in the first op's done cycle
        run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, "b2b_first");
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "b2b_second");
        tick();

        // kill in IDLE wins over a same-cycle start
        start = 1'b1; kill = 1'b1; op = 2'b00; op_a = 32'd1; op_b = 32'd1;
        tick();
        start = 1'b0; kill = 1'b0;
        chk("kill_idle_blocks_start", {31'd0, busy}, 32'd0);
        tick();

        // kill at cycle 20 of MULHU
        start = 1'b1; op = 2'b11; op_a = 32'h1234_5678; op_b = 32'd2;
        tick();
        start = 1'b0;
        repeat (19) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy_next", {31'd0, busy}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("kill_no_done", {31'd0, ok}, 32'd1);
        chk("kill_result_kept", result, 32'h0000_0000);
        run_op(2'b00, 32'd2, 32'd2, 32'h0000_0004, "after_kill");
        tick();

        // Asynchronous reset at cycle 15 of an operation
        start = 1'b1; op = 2'b00; op_a = 32'd7; op_b = 32'd6;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b0;
        #1;
        chk("amid_rst_busy", {31'd0, busy}, 32'd0);
        chk("amid_rst_done", {31'd0, done}, 32'd0);
        chk("amid_rst_result", result, 32'd0);
        tick(); tick();
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("rst_release_no_done", {31'd0, ok}, 32'd1);
        run_op(2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, "after_reset");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Iterative sequencer for the RV32M multiply path: accepts one MUL/MULH/MULHSU/MULHU request from the execute stage, runs a radix-2 shift-add loop over XLEN cycles under control of an internal iteration down-counter, applies sign correction, and returns the selected 32-bit product half with a one-cycle done pulse. It sits between the ALU issue logic and the register-file writeback mux and owns the multiply datapath exclusively; the pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width.
- `CW`, 5: iteration counter width; must satisfy 2^CW = XLEN.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `kill`  in  1  pipeline flush; aborts an operation in flight.
- `op`  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- `op_a`  in  XLEN  multiplicand (rs1), captured on accept.
- `op_b`  in  XLEN  multiplier (rs2), captured on accept.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  XLEN  selected product half; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX. Reset state IDLE.
- IDLE: `start`=1 → capture `|op_a|`, `|op_b|` (magnitude when the operand is treated as signed and MSB=1, raw otherwise), latch `op`, latch `neg` = sign(a) XOR sign(b) (signedness per `op`), clear 2·XLEN accumulator, load counter with XLEN-1 → CALC.
- a signed: MULH, MULHSU. b signed: MULH only. MUL uses the unsigned path; the low half is sign-independent.
- CALC, each cycle: if multiplier LSB=1, acc_hi ← acc_hi + multiplicand (XLEN+1-bit sum keeps the carry); shift {carry, acc_hi, acc_lo} right by 1, with the multiplier bit shifted out of acc_lo. Counter decrements. Counter=0 in CALC → FIX (exactly XLEN CALC cycles).
- FIX: product ← `neg` ? two's complement of the 2·XLEN accumulator : accumulator; `result` ← low half for MUL, high half otherwise; `done` ← 1 → IDLE.
- Magnitude of -2^(XLEN-1) is 2^(XLEN-1) as an unsigned value; no overflow special case.
- `kill` in CALC or FIX → IDLE next cycle; no `done`; `result` unchanged. `kill` in IDLE has no effect and blocks a same-cycle `start` (kill wins).
- `start` while `busy`=1 is ignored (not queued).

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, counter=0, state IDLE.
- `start` sampled at the end of cycle N → `busy`=1 in cycles N+1..N+33 (32 CALC + 1 FIX at XLEN=32) → `done`=1 and `result` valid in cycle N+34 with `busy`=0.
- `busy` is a combinational decode of state != IDLE; `done` and `result` are registered.
- Back-to-back: `start` is accepted in the `done` cycle (state is IDLE); next `done` at N+68.
- `reset` asserted mid-operation: immediate return to all reset values; no `done` after release.
- `kill` in cycle K (state CALC/FIX) → `busy`=0 in K+1.

## Test plan
- MUL 7 × 6, `start` at cycle 0 → `done` at cycle 34, `result`=0x0000002A; `busy` high for cycles 1–33 only.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result`=0xFFFFFFFE; MULH same operands (-1 × -1) → 0x00000000; MULHSU same operands → 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MUL 0x80000000 × 0xFFFFFFFF → 0x80000000.
- Back-to-back: MUL 3 × 5 then `start` in the done cycle with MUL 0x10000 × 0x10000 → 0x0000000F, then 0x00000000 exactly 34 cycles later; a `start` pulse at cycle 10 of the first op is ignored.
- `kill` at cycle 20 of MULHU 0x12345678 × 2 → `busy`=0 at cycle 21, no `done`, `result` keeps its prior value; new MUL 2 × 2 → 0x00000004.
- `reset` low at cycle 15 of an operation → `busy`, `done`, `result`=0 immediately; no `done` after release; the next op completes normally.
